mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `icemem` data memory between the CPU (port 0) and a second bus master (port 1, e.g. program loader or debug port). Accepts one transaction at a time through a req/ack handshake, grants it round-robin, drives the memory read and write ports, and returns read data after the memory's fixed read latency. It sits between the masters and `icemem` in `icetop`.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter_rr_pick2.sv | 10 +
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the icemem arbiter, CPU and memory.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the two masters, the arbiter and the icemem ports.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack,   m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_read_address;
    logic [ADDR_W-1:0] mem_write_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  mem_read_data,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output mem_read_data,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  mem_read_address, mem_write_address, mem_write_data, mem_write_enable
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time gets it.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);
    assign grant_valid = |req;
    assign grant_id    = (req == 2'b11) ? ~last_grant : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// Shares single-port icemem between the CPU (port 0) and a second master (port 1).
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    arb_state_e        state, state_nxt;
    logic              last_grant, port_q, we_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_valid, grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req         ({bus.m1_req, bus.m0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = grant_id ? bus.m1_we    : bus.m0_we;
        sel_addr  = grant_id ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = grant_id ? bus.m1_wdata : bus.m0_wdata;
    end

    // Requests are only sampled in IDLE, so a dropped req can never stall the FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? DONE : WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant            <= 1'b1;
            port_q                <= 1'b0;
            we_q                  <= 1'b0;
            cnt                   <= '0;
            bus.mem_read_address  <= '0;
            bus.mem_write_address <= '0;
            bus.mem_write_data    <= '0;
            bus.mem_write_enable  <= 1'b0;
            bus.m0_ack            <= 1'b0;
            bus.m1_ack            <= 1'b0;
            bus.m0_rdata          <= '0;
            bus.m1_rdata          <= '0;
        end else begin
            bus.mem_write_enable <= 1'b0;
            // The address outputs double as the latched transaction address.
            if (state == IDLE && grant_valid) begin
                port_q                <= grant_id;
                last_grant            <= grant_id;
                we_q                  <= sel_we;
                bus.mem_read_address  <= sel_addr;
                bus.mem_write_address <= sel_addr;
                bus.mem_write_enable  <= sel_we;
                if (sel_we) bus.mem_write_data <= sel_wdata;
            end
            if (state == ISSUE)     cnt <= CNT_W'(READ_LATENCY - 1);
            else if (state == WAIT) cnt <= cnt - CNT_W'(1);
            if (state == WAIT && cnt == '0) begin
                if (port_q) bus.m1_rdata <= bus.mem_read_data;
                else        bus.m0_rdata <= bus.mem_read_data;
            end
            bus.m0_ack <= (state_nxt == DONE) && !port_q;
            bus.m1_ack <= (state_nxt == DONE) &&  port_q;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (READ_LATENCY 1 and 3) with behavioural icemem models.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem3 [256];
    logic [DW-1:0] p3_a, p3_b;

    // Memory models: read data appears READ_LATENCY cycles after the address.
    always @(posedge clk) begin
        bus1.mem_read_data <= mem1[bus1.mem_read_address];
        if (bus1.mem_write_enable) mem1[bus1.mem_write_address] = bus1.mem_write_data;
    end

    always @(posedge clk) begin
        p3_a <= mem3[bus3.mem_read_address];
        p3_b <= p3_a;
        bus3.mem_read_data <= p3_b;
        if (bus3.mem_write_enable) mem3[bus3.mem_write_address] = bus3.mem_write_data;
    end

    task automatic test_reset();
        #12;
        n_cmp++; if ({bus1.m0_ack, bus1.m1_ack, bus1.mem_write_enable} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctl1: got %b want 000", {bus1.m0_ack, bus1.m1_ack, bus1.mem_write_enable}); end
        n_cmp++; if ({bus1.m0_rdata, bus1.m1_rdata, bus1.mem_write_data} !== '0) begin
            n_bad++; $display("FAIL reset_data1: got %h %h %h want 0", bus1.m0_rdata, bus1.m1_rdata, bus1.mem_write_data); end
        n_cmp++; if ({bus1.mem_read_address, bus1.mem_write_address} !== 16'h0) begin
            n_bad++; $display("FAIL reset_addr1: got %h %h want 0", bus1.mem_read_address, bus1.mem_write_address); end
        n_cmp++; if ({bus3.m0_ack, bus3.m1_ack, bus3.mem_write_enable, bus3.m0_rdata, bus3.m1_rdata,
                      bus3.mem_write_data, bus3.mem_read_address, bus3.mem_write_address} !== '0) begin
            n_bad++; $display("FAIL reset_dut3: outputs not all zero"); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_p0_write_read();
        int n;
        int m1_acks = 0;
        repeat (2) @(negedge clk);
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b1; bus1.m0_addr = 8'h10; bus1.m0_wdata = 32'hDEADBEEF;
        n = 0;
        do begin @(posedge clk); #1; n++; if (bus1.m1_ack) m1_acks++; end while (!bus1.m0_ack && n < 20);
        bus1.m0_req = 1'b0;
        n_cmp++; if (n != 2) begin n_bad++; $display("FAIL p0_write_latency: got %0d want 2", n); end
        n_cmp++; if (mem1[8'h10] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL p0_write_mem: got %h want deadbeef", mem1[8'h10]); end
        repeat (2) @(negedge clk);
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; if (bus1.m1_ack) m1_acks++; end while (!bus1.m0_ack && n < 20);
        bus1.m0_req = 1'b0;
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL p0_read_latency: got %0d want 3", n); end
        n_cmp++; if (bus1.m0_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL p0_read_data: got %h want deadbeef", bus1.m0_rdata); end
        n_cmp++; if (m1_acks != 0) begin n_bad++; $display("FAIL p0_m1_ack: got %0d pulses want 0", m1_acks); end
    endtask

    task automatic test_tie_from_reset();
        int n = 0, t0 = 0, t1 = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b1; bus1.m0_addr = 8'h01; bus1.m0_wdata = 32'h11;
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b1; bus1.m1_addr = 8'h02; bus1.m1_wdata = 32'h22;
        while ((t0 == 0 || t1 == 0) && n < 30) begin
            @(posedge clk); #1; n++;
            if (bus1.m0_ack) begin t0 = n; bus1.m0_req = 1'b0; end
            if (bus1.m1_ack) begin t1 = n; bus1.m1_req = 1'b0; end
        end
        bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
        n_cmp++; if (t0 != 2) begin n_bad++; $display("FAIL tie_m0_ack: got cycle %0d want 2", t0); end
        n_cmp++; if (t1 != 5) begin n_bad++; $display("FAIL tie_m1_ack: got cycle %0d want 5", t1); end
        n_cmp++; if (mem1[8'h01] !== 32'h11 || mem1[8'h02] !== 32'h22) begin
            n_bad++; $display("FAIL tie_mem: got %h %h want 11 22", mem1[8'h01], mem1[8'h02]); end
    endtask

    task automatic test_contention();
        int idx0 = 0, idx1 = 0, k = 0, n = 0;
        for (int i = 0; i < 8; i++) begin
            mem1[8'(8'h40 + i)] = 32'hA000_0000 + 32'(i);
            mem1[8'(8'h60 + i)] = 32'hB000_0000 + 32'(i);
        end
        repeat (2) @(negedge clk);
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 8'h40;
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 8'h60;
        while (k < 16 && n < 200) begin
            @(posedge clk); #1; n++;
            if (bus1.m0_ack) begin
                n_cmp++; if (k % 2 != 0) begin n_bad++; $display("FAIL rr_order: ack %0d got port 0 want port 1", k); end
                n_cmp++; if (bus1.m0_rdata !== 32'hA000_0000 + 32'(idx0)) begin
                    n_bad++; $display("FAIL rr_m0_data: got %h want %h", bus1.m0_rdata, 32'hA000_0000 + 32'(idx0)); end
                idx0++; k++;
                if (idx0 < 8) bus1.m0_addr = 8'(8'h40 + idx0); else bus1.m0_req = 1'b0;
            end
            if (bus1.m1_ack) begin
                n_cmp++; if (k % 2 != 1) begin n_bad++; $display("FAIL rr_order: ack %0d got port 1 want port 0", k); end
                n_cmp++; if (bus1.m1_rdata !== 32'hB000_0000 + 32'(idx1)) begin
                    n_bad++; $display("FAIL rr_m1_data: got %h want %h", bus1.m1_rdata, 32'hB000_0000 + 32'(idx1)); end
                idx1++; k++;
                if (idx1 < 8) bus1.m1_addr = 8'(8'h60 + idx1); else bus1.m1_req = 1'b0;
            end
        end
        bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
        n_cmp++; if (k != 16) begin n_bad++; $display("FAIL rr_count: got %0d acks want 16", k); end
    endtask

    task automatic test_latency3();
        int n = 0;
        logic we_seen = 1'b0;
        mem3[8'h7F] = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        bus3.m0_req = 1'b1; bus3.m0_we = 1'b0; bus3.m0_addr = 8'h7F;
        do begin @(posedge clk); #1; n++; we_seen |= bus3.mem_write_enable; end while (!bus3.m0_ack && n < 20);
        bus3.m0_req = 1'b0;
        n_cmp++; if (n != 5) begin n_bad++; $display("FAIL lat3_latency: got %0d want 5", n); end
        n_cmp++; if (bus3.m0_rdata !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL lat3_data: got %h want a5a5a5a5", bus3.m0_rdata); end
        n_cmp++; if (we_seen !== 1'b0) begin n_bad++; $display("FAIL lat3_we: got %b want 0", we_seen); end
    endtask

    task automatic test_isolation();
        int n = 0, m0_acks = 0;
        logic held = 1'b1;
        mem1[8'h30] = 32'h12345678;
        mem1[8'h20] = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 8'h30;
        do begin @(posedge clk); #1; n++; end while (!bus1.m0_ack && n < 20);
        bus1.m0_req = 1'b0;
        n_cmp++; if (bus1.m0_rdata !== 32'h12345678) begin
            n_bad++; $display("FAIL iso_m0_read: got %h want 12345678", bus1.m0_rdata); end
        repeat (2) @(negedge clk);
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 8'h20;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (bus1.m0_ack) m0_acks++;
            if (bus1.m0_rdata !== 32'h12345678) held = 1'b0;
        end while (!bus1.m1_ack && n < 20);
        bus1.m1_req = 1'b0;
        n_cmp++; if (bus1.m1_rdata !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL iso_m1_read: got %h want cafef00d", bus1.m1_rdata); end
        n_cmp++; if (held !== 1'b1 || m0_acks != 0) begin
            n_bad++; $display("FAIL iso_m0_hold: held=%b acks=%0d want held=1 acks=0", held, m0_acks); end
    endtask

    task automatic test_reset_mid();
        int n = 0, t0 = 0, t1 = 0;
        mem1[8'h05] = 32'h0;
        repeat (2) @(negedge clk);
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b1; bus1.m1_addr = 8'h05; bus1.m1_wdata = 32'h55;
        @(posedge clk); #1;
        n_cmp++; if (bus1.mem_write_enable !== 1'b1) begin
            n_bad++; $display("FAIL rst_issue_we: got %b want 1", bus1.mem_write_enable); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus1.mem_write_enable !== 1'b0) begin
            n_bad++; $display("FAIL rst_we_drop: got %b want 0", bus1.mem_write_enable); end
        n_cmp++; if ({bus1.m0_rdata, bus1.m1_rdata, bus1.mem_write_data, bus1.mem_read_address, bus1.mem_write_address} !== '0) begin
            n_bad++; $display("FAIL rst_outputs: got %h %h %h %h %h want 0", bus1.m0_rdata, bus1.m1_rdata,
                              bus1.mem_write_data, bus1.mem_read_address, bus1.mem_write_address); end
        bus1.m1_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus1.m0_ack !== 1'b0 || bus1.m1_ack !== 1'b0 || mem1[8'h05] !== 32'h0) begin
            n_bad++; $display("FAIL rst_no_ack: acks=%b%b mem=%h want 00 0", bus1.m0_ack, bus1.m1_ack, mem1[8'h05]); end
        @(negedge clk); rst_n = 1'b1;
        bus1.m0_req = 1'b1; bus1.m0_we = 1'b0; bus1.m0_addr = 8'h40;
        bus1.m1_req = 1'b1; bus1.m1_we = 1'b0; bus1.m1_addr = 8'h60;
        while ((t0 == 0 || t1 == 0) && n < 30) begin
            @(posedge clk); #1; n++;
            if (bus1.m0_ack) begin t0 = n; bus1.m0_req = 1'b0; end
            if (bus1.m1_ack) begin t1 = n; bus1.m1_req = 1'b0; end
        end
        bus1.m0_req = 1'b0; bus1.m1_req = 1'b0;
        n_cmp++; if (t0 != 3 || t1 != 7) begin
            n_bad++; $display("FAIL rst_tie_order: got m0@%0d m1@%0d want m0@3 m1@7", t0, t1); end
        n_cmp++; if (bus1.m0_rdata !== 32'hA000_0000 || bus1.m1_rdata !== 32'hB000_0000) begin
            n_bad++; $display("FAIL rst_tie_data: got %h %h want a0000000 b0000000", bus1.m0_rdata, bus1.m1_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem3[i] = '0; end
        bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_addr = '0; bus1.m0_wdata = '0;
        bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_addr = '0; bus1.m1_wdata = '0;
        bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_addr = '0; bus3.m1_wdata = '0;
        test_reset();
        test_p0_write_read();
        test_tie_from_reset();
        test_contention();
        test_latency3();
        test_isolation();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
